load_store_unit: RTL and testbench

Sits between the core's execute stage and the unified word-addressed data memory, translating RV32I loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word accesses. The memory supports only aligned full-word writes and a combinational word read, so sub-word stores use a read-modify-write sequence. Loads are lane-extracted and sign/zero-extended. Misaligned or illegal requests are rejected with an error response and never touch memory.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 60 ++++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings and FSM states.
package lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned WORDS = 64;

  // RV32I load/store funct3 encodings (stores use B/H/W only)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_t;

  // Illegal funct3 or an address not aligned to the access size.
  function automatic logic req_bad(input logic we, input logic [2:0] funct3,
                                   input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (we) illegal = funct3[2] || (funct3[1:0] == 2'b11);
    else    illegal = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Pure lane logic: load extract/extend and sub-word store merge.
// Ports: word (memory word), wdata (right-aligned store data), addr_lo (byte
// offset), funct3 -> load_data_c (extended load), store_word_c (merged word).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] store_word_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load: pick the addressed lane, then extend by funct3
  always_comb begin
    byte_sel    = word[7:0];
    half_sel    = addr_lo[1] ? word[31:16] : word[15:0];
    load_data_c = word;
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    case (funct3)
      F3_B:    load_data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_c = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data_c = {24'd0, byte_sel};
      F3_HU:   load_data_c = {16'd0, half_sel};
      default: load_data_c = word;
    endcase
  end

  // Store: overlay the low byte/half of wdata onto the target lane
  always_comb begin
    store_word_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        store_word_c = word;
        case (addr_lo)
          2'd0:    store_word_c[7:0]   = wdata[7:0];
          2'd1:    store_word_c[15:8]  = wdata[7:0];
          2'd2:    store_word_c[23:16] = wdata[7:0];
          default: store_word_c[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        store_word_c = word;
        if (addr_lo[1]) store_word_c[31:16] = wdata[15:0];
        else            store_word_c[15:0]  = wdata[15:0];
      end
      default: store_word_c = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-only data memory. Sub-word stores are
// done as read-modify-write; loads are lane-extracted and extended.
// Ports: clk/rst (sync active-high); req_* request handshake from execute;
// resp_* one-cycle completion with error flag and load data; mem_* word port
// to memory with combinational mem_read_data.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic            resp_error,
  output logic [XLEN-1:0] resp_rdata,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write_enable,
  input  logic [XLEN-1:0] mem_read_data
);

  lsu_state_t      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            error_q, error_d;

  logic [XLEN-1:0] load_data_c;
  logic [XLEN-1:0] store_word_c;

  lsu_align u_align (
    .word         (mem_read_data),
    .wdata        (wdata_q),
    .addr_lo      (addr_q[1:0]),
    .funct3       (f3_q),
    .load_data_c  (load_data_c),
    .store_word_c (store_word_c)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Next state; response fields only change on entry to RESP
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_bad(req_we, req_funct3, req_addr[1:0])) begin
            state_d = ST_RESP;
            error_d = 1'b1;
            rdata_d = '0;
          end else if (!req_we) begin
            state_d = ST_LOAD;
          end else if (req_funct3 == F3_W) begin
            state_d = ST_WRITE;
            buf_d   = req_wdata;
          end else begin
            state_d = ST_RMW_READ;
          end
        end
      end
      ST_LOAD: begin
        rdata_d = load_data_c;
        error_d = 1'b0;
        state_d = ST_RESP;
      end
      ST_RMW_READ: begin
        buf_d   = store_word_c;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        rdata_d = '0;
        error_d = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready        = (state_q == ST_IDLE);
  assign resp_valid       = (state_q == ST_RESP);
  assign resp_error       = error_q;
  assign resp_rdata       = rdata_q;
  assign mem_address      = {addr_q[XLEN-1:2], 2'b00};
  assign mem_write_data   = buf_q;
  // Gated by rst so a reset landing in WRITE commits nothing
  assign mem_write_enable = (state_q == ST_WRITE) && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_error       (resp_error),
    .resp_rdata       (resp_rdata),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  // Attached word memory (64 words, address wraps)
  logic [31:0] tb_mem [64];
  logic        mem_init;

  function automatic logic [31:0] init_pattern(input int i);
    return 32'(i + 1) * 32'h9E37_79B9;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= init_pattern(i);
    end else if (mem_write_enable) begin
      tb_mem[mem_address[7:2]] <= mem_write_data;
    end
  end
  assign mem_read_data = tb_mem[mem_address[7:2]];

  // Reference model: byte-addressed memory image
  logic [7:0] ref_bytes [256];

  function automatic logic [31:0] ref_word(input int w);
    return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
  endfunction

  task automatic model_apply(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic e,
                             output logic [31:0] rd, output int lat);
    int size;
    bit legal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e  = !legal || ((addr % 32'(size)) != 0);
    rd = 32'd0;
    if (e) begin
      lat = 1;
    end else if (!we) begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_bytes[8'(addr + 32'(i))]) << (8 * i));
      if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      rd  = v;
      lat = 2;
    end else begin
      for (int i = 0; i < size; i++) ref_bytes[8'(addr + 32'(i))] = 8'(wdata >> (8 * i));
      lat = (size == 4) ? 2 : 3;
    end
  endtask

  // Drive one request; report response latency (cycles after the accepting
  // edge), write activity and response fields. Returns at the RESP negedge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output int we_cyc,
                       output int we_cnt, output logic [31:0] waddr,
                       output logic [31:0] rd, output logic e);
    lat = 0; we_cyc = 0; we_cnt = 0; waddr = 32'd0; rd = 32'd0; e = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 8 && !req_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (mem_write_enable) begin we_cnt++; we_cyc = n; waddr = mem_address; end
      if (resp_valid) begin lat = n; rd = resp_rdata; e = resp_error; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if (resp_error !== 1'b0) begin bad++; $display("FAIL reset_resp_error got=%b exp=0", resp_error); end
    total++; if (resp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    total++; if (mem_address !== 32'd0) begin bad++; $display("FAIL reset_mem_address got=%h exp=0", mem_address); end
    total++; if (mem_write_data !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", mem_write_data); end
    total++; if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_write_enable); end
    rst = 1'b0; mem_init = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          lat;
    logic [31:0] word;
  } dir_t;

  task automatic test_directed();
    dir_t tbl [8];
    int lat, we_cyc, we_cnt, m_lat;
    logic [31:0] waddr, rd, m_rd;
    logic e, m_e;
    tbl = '{
      '{1'b1, 3'd2, 32'h8, 32'hDEADBEEF, 32'h0,        2, 32'hDEADBEEF},
      '{1'b0, 3'd2, 32'h8, 32'h0,        32'hDEADBEEF, 2, 32'hDEADBEEF},
      '{1'b0, 3'd0, 32'h9, 32'h0,        32'hFFFFFFBE, 2, 32'hDEADBEEF},
      '{1'b0, 3'd4, 32'h9, 32'h0,        32'h000000BE, 2, 32'hDEADBEEF},
      '{1'b0, 3'd1, 32'hA, 32'h0,        32'hFFFFDEAD, 2, 32'hDEADBEEF},
      '{1'b0, 3'd5, 32'hA, 32'h0,        32'h0000DEAD, 2, 32'hDEADBEEF},
      '{1'b1, 3'd0, 32'hB, 32'h00000012, 32'h0,        3, 32'h12ADBEEF},
      '{1'b1, 3'd1, 32'h8, 32'h00005678, 32'h0,        3, 32'h12AD5678}
    };
    foreach (tbl[i]) begin
      issue(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, lat, we_cyc, we_cnt, waddr, rd, e);
      model_apply(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_e, m_rd, m_lat);
      @(negedge clk);
      total++; if (lat !== tbl[i].lat) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, tbl[i].lat); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL dir%0d_error got=%b exp=0", i, e); end
      total++; if (rd !== tbl[i].rd) begin bad++; $display("FAIL dir%0d_rdata got=%h exp=%h", i, rd, tbl[i].rd); end
      total++; if (tb_mem[2] !== tbl[i].word) begin bad++; $display("FAIL dir%0d_mem got=%h exp=%h", i, tb_mem[2], tbl[i].word); end
      total++; if (we_cnt !== (tbl[i].we ? 1 : 0)) begin bad++; $display("FAIL dir%0d_we_count got=%0d exp=%0d", i, we_cnt, tbl[i].we ? 1 : 0); end
      if (tbl[i].we) begin
        total++; if (we_cyc !== tbl[i].lat - 1) begin bad++; $display("FAIL dir%0d_we_cycle got=%0d exp=%0d", i, we_cyc, tbl[i].lat - 1); end
        total++; if (waddr !== 32'h8) begin bad++; $display("FAIL dir%0d_waddr got=%h exp=8", i, waddr); end
      end
    end
  endtask

  task automatic test_errors();
    logic        we_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3_t [3] = '{3'd2, 3'd1, 3'd3};
    logic [31:0] ad_t [3] = '{32'h6, 32'h3, 32'h8};
    int lat, we_cyc, we_cnt;
    logic [31:0] waddr, rd;
    logic e;
    for (int i = 0; i < 3; i++) begin
      issue(we_t[i], f3_t[i], ad_t[i], 32'hFFFF_FFFF, lat, we_cyc, we_cnt, waddr, rd, e);
      total++; if (lat !== 1) begin bad++; $display("FAIL err%0d_latency got=%0d exp=1", i, lat); end
      total++; if (e !== 1'b1) begin bad++; $display("FAIL err%0d_error got=%b exp=1", i, e); end
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL err%0d_rdata got=%h exp=0", i, rd); end
      total++; if (we_cnt !== 0) begin bad++; $display("FAIL err%0d_we_count got=%0d exp=0", i, we_cnt); end
      @(negedge clk);
      total++; if (tb_mem[0] !== ref_word(0) || tb_mem[1] !== ref_word(1) || tb_mem[2] !== ref_word(2))
        begin bad++; $display("FAIL err%0d_mem got=%h_%h_%h exp=%h_%h_%h", i, tb_mem[2], tb_mem[1], tb_mem[0], ref_word(2), ref_word(1), ref_word(0)); end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] prior;
    int lat, we_cyc, we_cnt;
    logic [31:0] waddr, rd;
    logic e;
    prior = ref_word(1);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h4; req_wdata = 32'h1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (mem_write_enable !== 1'b1) begin bad++; $display("FAIL rstmid_in_write got=%b exp=1", mem_write_enable); end
    rst = 1'b1;
    #1;
    total++; if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL rstmid_we_gated got=%b exp=0", mem_write_enable); end
    @(negedge clk);
    rst = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_resp got=%b exp=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", req_ready); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_late_resp got=%b exp=0", resp_valid); end
    total++; if (tb_mem[1] !== prior) begin bad++; $display("FAIL rstmid_mem got=%h exp=%h", tb_mem[1], prior); end
    issue(1'b0, 3'd2, 32'h4, 32'h0, lat, we_cyc, we_cnt, waddr, rd, e);
    total++; if (rd !== prior || e !== 1'b0) begin bad++; $display("FAIL rstmid_reload got=%h/%b exp=%h/0", rd, e, prior); end
  endtask

  task automatic test_random();
    int lat, we_cyc, we_cnt, m_lat, idx;
    logic [31:0] waddr, rd, m_rd, addr, wdata;
    logic [2:0] f3;
    logic we, e, m_e;
    for (int i = 0; i < 40; i++) begin
      we    = 1'($urandom_range(0, 1));
      f3    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      addr  = $urandom;
      wdata = $urandom;
      issue(we, f3, addr, wdata, lat, we_cyc, we_cnt, waddr, rd, e);
      model_apply(we, f3, addr, wdata, m_e, m_rd, m_lat);
      @(negedge clk);
      idx = int'(addr[7:2]);
      total++; if (lat !== m_lat || e !== m_e || rd !== m_rd)
        begin bad++; $display("FAIL rand%0d_resp we=%b f3=%0d a=%h got=%0d/%b/%h exp=%0d/%b/%h", i, we, f3, addr, lat, e, rd, m_lat, m_e, m_rd); end
      total++; if (we_cnt !== ((we && !m_e) ? 1 : 0)) begin bad++; $display("FAIL rand%0d_we_count got=%0d", i, we_cnt); end
      total++; if (tb_mem[idx] !== ref_word(idx)) begin bad++; $display("FAIL rand%0d_mem got=%h exp=%h", i, tb_mem[idx], ref_word(idx)); end
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_e_q [$];
    logic [31:0] exp_rd_q [$];
    logic        p_we, acc_prev, m_e, ee;
    logic [31:0] p_addr, p_wdata, m_rd, er;
    int          m_lat, nacc, nresp;
    p_we = 1'b1; p_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; p_wdata = $urandom;
    acc_prev = 1'b0; nacc = 0; nresp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'd2;
    req_we = p_we; req_addr = p_addr; req_wdata = p_wdata;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (acc_prev) begin
        if (p_we) p_we = 1'b0;
        else begin p_we = 1'b1; p_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; p_wdata = $urandom; end
        req_we = p_we; req_addr = p_addr; req_wdata = p_wdata;
        acc_prev = 1'b0;
      end
      if (resp_valid) begin
        nresp++;
        total++;
        if (exp_e_q.size() == 0) begin bad++; $display("FAIL b2b_extra_resp cyc=%0d got=1 exp=0", cyc); end
        else begin
          ee = exp_e_q.pop_front(); er = exp_rd_q.pop_front();
          if (resp_error !== ee || resp_rdata !== er) begin bad++; $display("FAIL b2b_resp cyc=%0d got=%b/%h exp=%b/%h", cyc, resp_error, resp_rdata, ee, er); end
        end
      end
      if (req_ready) begin
        total++; if (exp_e_q.size() != 0) begin bad++; $display("FAIL b2b_ready_busy cyc=%0d got=1 exp=0", cyc); end
        model_apply(p_we, 3'd2, p_addr, p_wdata, m_e, m_rd, m_lat);
        exp_e_q.push_back(m_e); exp_rd_q.push_back(m_rd);
        acc_prev = 1'b1; nacc++;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int d = 0; d < 8; d++) begin
      if (resp_valid) begin
        nresp++;
        total++;
        if (exp_e_q.size() == 0) begin bad++; $display("FAIL b2b_extra_resp drain got=1 exp=0"); end
        else begin
          ee = exp_e_q.pop_front(); er = exp_rd_q.pop_front();
          if (resp_error !== ee || resp_rdata !== er) begin bad++; $display("FAIL b2b_resp drain got=%b/%h exp=%b/%h", resp_error, resp_rdata, ee, er); end
        end
      end
      @(negedge clk);
    end
    total++; if (nresp !== nacc) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", nresp, nacc); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = 8'(init_pattern(i) >> (8 * b));
    test_reset();
    test_directed();
    test_errors();
    test_reset_mid_write();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
